luhn_check_gen: RTL and testbench

// Serial Luhn check-digit generator, the transmit-side counterpart of the PAN validator.

---
 rtl/luhn_check_gen.sv | 165 ++++++++++++++++
 tb/tb_luhn_check_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/luhn_check_gen.sv
// Serial Luhn check-digit generator: collects PAN_DIGITS-1 payload BCD digits
// over valid/ready and presents the complete PAN (payload + check digit).
module luhn_check_gen #(
  parameter int PAN_DIGITS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [3:0]  i_digit_in,
  input  logic        i_digit_valid,
  output logic        o_digit_ready,
  output logic [75:0] o_pan_bcd,
  output logic        o_pan_ready,
  input  logic        i_pan_ack,
  output logic [3:0]  o_check_digit,
  output logic        o_busy,
  output logic        o_bcd_err
);

  localparam logic [4:0] LAST_IDX = 5'(PAN_DIGITS - 2);
  localparam int         CHK_LSB  = 4 * (PAN_DIGITS - 1);
  localparam logic       DBL_PAR  = 1'((PAN_DIGITS - 1) % 2);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CALC, S_OUT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [75:0] r_pan_bcd;
  logic [75:0] w_pan_nxt;
  logic [3:0]  r_acc;
  logic [3:0]  w_acc_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [3:0]  r_check;
  logic [3:0]  w_check_nxt;
  logic        r_pan_ready;
  logic        w_pan_ready_nxt;
  logic        r_bcd_err;
  logic        w_bcd_err_nxt;

  logic        w_dbl;
  logic [4:0]  w_two;
  logic [4:0]  w_term;
  logic [4:0]  w_sum;
  logic [4:0]  w_sum_m10;
  logic [3:0]  w_acc_add;
  logic [3:0]  w_check_calc;

  // Digit weight alternates from the right-hand end of the payload, so the
  // doubling phase depends on both the PAN length and the digit position.
  assign w_dbl        = DBL_PAR ^ r_cnt[0];
  assign w_two        = {i_digit_in, 1'b0};
  assign w_term       = w_dbl ? ((i_digit_in <= 4'd4) ? w_two : (w_two - 5'd9))
                              : {1'b0, i_digit_in};
  assign w_sum        = {1'b0, r_acc} + w_term;
  assign w_sum_m10    = w_sum - 5'd10;
  assign w_acc_add    = (w_sum >= 5'd10) ? w_sum_m10[3:0] : w_sum[3:0];
  assign w_check_calc = (r_acc == 4'd0) ? 4'd0 : (4'd10 - r_acc);

  assign o_digit_ready = (r_state == S_COLLECT);
  assign o_busy        = (r_state != S_IDLE);
  assign o_pan_bcd     = r_pan_bcd;
  assign o_pan_ready   = r_pan_ready;
  assign o_check_digit = r_check;
  assign o_bcd_err     = r_bcd_err;

  // Next-state and datapath update; abort overrides every state.
  always_comb begin
    w_state_nxt     = r_state;
    w_pan_nxt       = r_pan_bcd;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_check_nxt     = r_check;
    w_pan_ready_nxt = r_pan_ready;
    w_bcd_err_nxt   = r_bcd_err;
    if (i_abort) begin
      w_state_nxt     = S_IDLE;
      w_pan_nxt       = 76'd0;
      w_pan_ready_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_state_nxt   = S_COLLECT;
            w_pan_nxt     = 76'd0;
            w_acc_nxt     = 4'd0;
            w_cnt_nxt     = 5'd0;
            w_check_nxt   = 4'd0;
            w_bcd_err_nxt = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_COLLECT: begin
          if (i_digit_valid) begin
            if (i_digit_in > 4'd9) begin
              w_state_nxt   = S_IDLE;
              w_pan_nxt     = 76'd0;
              w_bcd_err_nxt = 1'b1;
            end else begin
              w_pan_nxt[{r_cnt, 2'b00} +: 4] = i_digit_in;
              w_acc_nxt = w_acc_add;
              w_cnt_nxt = r_cnt + 5'd1;
              if (r_cnt == LAST_IDX) begin
                w_state_nxt = S_CALC;
              end else begin
                w_state_nxt = S_COLLECT;
              end
            end
          end else begin
            w_state_nxt = S_COLLECT;
          end
        end
        S_CALC: begin
          w_pan_nxt[CHK_LSB +: 4] = w_check_calc;
          w_check_nxt     = w_check_calc;
          w_pan_ready_nxt = 1'b1;
          w_state_nxt     = S_OUT;
        end
        S_OUT: begin
          if (i_pan_ack) begin
            w_pan_ready_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
          end else begin
            w_state_nxt = S_OUT;
          end
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_pan_ready_nxt = 1'b0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pan_bcd   <= 76'd0;
      r_acc       <= 4'd0;
      r_cnt       <= 5'd0;
      r_check     <= 4'd0;
      r_pan_ready <= 1'b0;
      r_bcd_err   <= 1'b0;
    end else begin
      r_pan_bcd   <= w_pan_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_check     <= w_check_nxt;
      r_pan_ready <= w_pan_ready_nxt;
      r_bcd_err   <= w_bcd_err_nxt;
    end
  end

endmodule

// File: tb/tb_luhn_check_gen.sv
// Scoreboard bench for luhn_check_gen: random payloads against a plain-arithmetic
// Luhn model, plus directed error, abort and reset scenarios.
module tb_luhn_check_gen;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        valid = 1'b0;
  logic        dready;
  logic [75:0] pan;
  logic        pready;
  logic        ack = 1'b0;
  logic [3:0]  chk;
  logic        busy;
  logic        berr;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    logic [75:0] pan;
    logic [3:0]  chk;
    int          rdy_cyc;
  } exp_t;
  exp_t sb[$];

  luhn_check_gen #(.PAN_DIGITS(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_digit_in(digit), .i_digit_valid(valid), .o_digit_ready(dready),
    .o_pan_bcd(pan), .o_pan_ready(pready), .i_pan_ack(ack),
    .o_check_digit(chk), .o_busy(busy), .o_bcd_err(berr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Luhn check digit: double every other payload digit counting from the right.
  function automatic int ref_check(input int pay[19]);
    int sum = 0;
    for (int i = 0; i < N - 1; i++) begin
      int v = pay[i];
      if (((N - 1 - i) % 2) == 1) v = 2 * v;
      sum += v / 10 + v % 10;
    end
    return (10 - sum % 10) % 10;
  endfunction

  // Validator view: a full PAN is valid when its Luhn sum is a multiple of 10.
  function automatic bit luhn_ok(input logic [75:0] p);
    int sum = 0;
    for (int k = 0; k < N; k++) begin
      int v = int'(p[4*k +: 4]);
      if (((N - 1 - k) % 2) == 1) v = 2 * v;
      sum += v / 10 + v % 10;
    end
    return (sum % 10) == 0;
  endfunction

  // Monitor: pops an expectation at each rising pan_ready and checks hold stability.
  logic        prev_rdy = 1'b0;
  logic [75:0] held;
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy = 1'b0;
    end else begin
      if (pready && !prev_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_pan_ready", 76'd1, 76'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pan_bcd", pan, e.pan);
          check("check_digit", {72'd0, chk}, {72'd0, e.chk});
          check("latency_cycle", 76'(cyc), 76'(e.rdy_cyc));
          check("loopback_valid", {75'd0, luhn_ok(pan)}, 76'd1);
        end
        held = pan;
      end else if (pready) begin
        check("pan_stable_while_ready", pan, held);
      end
      prev_rdy = pready;
    end
  end

  task automatic run_pan(input int pay[19], input bit gaps, input int ack_dly,
                         input bit poke_start, input bit calc_ack, input int force_chk);
    int          c;
    int          t;
    logic [75:0] p;
    exp_t        e;
    c = (force_chk >= 0) ? force_chk : ref_check(pay);
    p = 76'd0;
    for (int i = 0; i < N - 1; i++) p[4*i +: 4] = 4'(pay[i]);
    p[4*(N-1) +: 4] = 4'(c);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        valid = 1'b0;
        digit = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      if (poke_start && i == 7) start = 1'b1;
      digit = 4'(pay[i]);
      valid = 1'b1;
      if (i == N - 2) begin
        e.pan = p; e.chk = 4'(c); e.rdy_cyc = cyc + 2;
        sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
    end
    valid = 1'b0;
    if (calc_ack) ack = 1'b1;
    t = 0;
    while (!pready && t < 40) begin
      @(negedge clk);
      ack = 1'b0;
      t++;
    end
    check("pan_ready_seen", {75'd0, pready}, 76'd1);
    repeat (ack_dly) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("busy_after_ack", {75'd0, busy}, 76'd0);
    check("pan_ready_after_ack", {75'd0, pready}, 76'd0);
    check("pan_hold_after_ack", pan, p);
    check("check_hold_after_ack", {72'd0, chk}, {72'd0, 4'(c)});
  endtask

  task automatic send_digits(input int n);
    for (int i = 0; i < n; i++) begin
      digit = 4'($urandom_range(0, 9));
      valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  initial begin
    int pay[19];
    int visa[15] = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6};

    #1;
    check("rst_async_pan", pan, 76'd0);
    check("rst_async_ready", {75'd0, pready}, 76'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_pan", pan, 76'd0);
    check("rst_flags", {71'd0, pready, dready, busy, berr, 1'b0}, 76'd0);
    check("rst_check", {72'd0, chk}, 76'd0);

    foreach (pay[i]) pay[i] = 0;
    for (int i = 0; i < 15; i++) pay[i] = visa[i];
    run_pan(pay, 1'b0, 0, 1'b0, 1'b0, 7);
    run_pan(pay, 1'b1, 10, 1'b0, 1'b0, 7);
    run_pan(pay, 1'b0, 2, 1'b1, 1'b1, 7);
    for (int i = 0; i < 15; i++) pay[i] = 9;
    run_pan(pay, 1'b0, 0, 1'b0, 1'b0, 5);
    for (int i = 0; i < 15; i++) pay[i] = 1;
    run_pan(pay, 1'b0, 0, 1'b0, 1'b0, 7);
    for (int i = 0; i < 15; i++) pay[i] = 0;
    run_pan(pay, 1'b0, 0, 1'b0, 1'b0, 0);

    // Bad BCD digit in position 6.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    send_digits(5);
    digit = 4'hC; valid = 1'b1;
    @(negedge clk) valid = 1'b0;
    check("bcd_err_set", {75'd0, berr}, 76'd1);
    check("bcd_err_idle", {74'd0, busy, dready}, 76'd0);
    check("bcd_err_pan_clr", pan, 76'd0);
    repeat (4) @(negedge clk);
    check("bcd_err_no_ready", {75'd0, pready}, 76'd0);
    abort = 1'b1; start = 1'b1;
    @(negedge clk) begin abort = 1'b0; start = 1'b0; end
    check("abort_start_idle", {75'd0, busy}, 76'd0);
    check("abort_keeps_bcd_err", {75'd0, berr}, 76'd1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("start_clears_bcd_err", {75'd0, berr}, 76'd0);
    check("start_busy", {74'd0, busy, dready}, 76'd3);

    // Abort after 8 digits, with a digit and start also presented.
    send_digits(8);
    check("partial_pan_nonidle", {75'd0, busy}, 76'd1);
    abort = 1'b1; start = 1'b1; valid = 1'b1; digit = 4'd3;
    @(negedge clk) begin abort = 1'b0; start = 1'b0; valid = 1'b0; end
    check("abort_idle", {74'd0, busy, pready}, 76'd0);
    check("abort_pan_clr", pan, 76'd0);
    for (int i = 0; i < 15; i++) pay[i] = $urandom_range(0, 9);
    run_pan(pay, 1'b1, 1, 1'b0, 1'b0, -1);

    // Asynchronous reset mid-collection.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    send_digits(4);
    #2 rst = 1'b1;
    #1;
    check("midop_rst_flags", {72'd0, pready, dready, busy, berr}, 76'd0);
    check("midop_rst_pan", pan, 76'd0);
    check("midop_rst_check", {72'd0, chk}, 76'd0);
    @(negedge clk) rst = 1'b0;

    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 15; i++) pay[i] = $urandom_range(0, 9);
      run_pan(pay, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), -1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 76'(sb.size()), 76'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
